// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: holds the IF/ID branch record, resolves the real
// direction from forwarded operands, and raises mispredict/flush/redirect.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_branch,
  input  logic              if_brpre,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              if_rvc,
  input  logic [12:0]       if_imm,
  input  logic [2:0]        id_funct3,
  input  logic [XLEN-1:0]   id_rs1,
  input  logic [XLEN-1:0]   id_rs2,
  output logic              pre_wrong,
  output logic              flush_if,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  logic            id_v;
  logic            id_pred;
  logic [XLEN-1:0] id_pc;
  logic            id_rvc;
  logic [XLEN-1:0] id_target;
  logic [XLEN-1:0] id_fall;
  logic [12:0]     imm_even;
  logic [XLEN-1:0] if_target;
  logic            taken;

  assign imm_even  = if_imm & 13'h1FFE;
  assign if_target = if_pc + {{(XLEN-13){imm_even[12]}}, imm_even};

  // The fall-through address is rebuilt in ID from the captured PC and size.
  assign id_fall = id_pc + (id_rvc ? XLEN'(2) : XLEN'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_v      <= 1'b0;
      id_pred   <= 1'b0;
      id_pc     <= '0;
      id_rvc    <= 1'b0;
      id_target <= '0;
    end else if (!stall) begin
      id_v      <= if_branch & ~pre_wrong;
      id_pred   <= if_brpre;
      id_pc     <= if_pc;
      id_rvc    <= if_rvc;
      id_target <= if_target;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (id_funct3)
      3'b000:  taken = (id_rs1 == id_rs2);
      3'b001:  taken = (id_rs1 != id_rs2);
      3'b100:  taken = ($signed(id_rs1) <  $signed(id_rs2));
      3'b101:  taken = ($signed(id_rs1) >= $signed(id_rs2));
      3'b110:  taken = (id_rs1 <  id_rs2);
      3'b111:  taken = (id_rs1 >= id_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign pre_wrong   = id_v & (taken != id_pred);
  assign flush_if    = pre_wrong;
  assign redirect_pc = pre_wrong ? (taken ? id_target : id_fall) : '0;

  // Statistics counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (!stall) begin
      if (id_v && (br_cnt != '1))
        br_cnt <= br_cnt + CNT_W'(1);
      if (pre_wrong && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; a second instance with
// narrow counters exercises saturation.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        if_branch;
  logic        if_brpre;
  logic [31:0] if_pc;
  logic        if_rvc;
  logic [12:0] if_imm;
  logic [2:0]  id_funct3;
  logic [31:0] id_rs1;
  logic [31:0] id_rs2;
  logic        pre_wrong;
  logic        flush_if;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt;
  logic [15:0] miss_cnt;
  logic        pre_wrong_s;
  logic        flush_if_s;
  logic [31:0] redirect_pc_s;
  logic [2:0]  br_cnt_s;
  logic [2:0]  miss_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_branch(if_branch), .if_brpre(if_brpre), .if_pc(if_pc),
    .if_rvc(if_rvc), .if_imm(if_imm),
    .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .pre_wrong(pre_wrong), .flush_if(flush_if), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_branch(if_branch), .if_brpre(if_brpre), .if_pc(if_pc),
    .if_rvc(if_rvc), .if_imm(if_imm),
    .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .pre_wrong(pre_wrong_s), .flush_if(flush_if_s), .redirect_pc(redirect_pc_s),
    .br_cnt(br_cnt_s), .miss_cnt(miss_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_if(input logic br, input logic pre, input logic [31:0] pc,
                        input logic rvc, input logic [12:0] imm);
    if_branch = br;
    if_brpre  = pre;
    if_pc     = pc;
    if_rvc    = rvc;
    if_imm    = imm;
  endtask

  task automatic set_id(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2);
    id_funct3 = f3;
    id_rs1    = rs1;
    id_rs2    = rs2;
  endtask

  // Inputs change on the falling edge; comb outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b000, 32'h0, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    #1;
    check_output("reset_pre_wrong", 32'(pre_wrong), 32'h0);
    check_output("reset_flush_if", 32'(flush_if), 32'h0);
    check_output("reset_redirect", redirect_pc, 32'h0);
    check_output("reset_br_cnt", 32'(br_cnt), 32'h0);
    check_output("reset_miss_cnt", 32'(miss_cnt), 32'h0);

    // BEQ predicted taken, actually taken
    tick();
    set_if(1'b1, 1'b1, 32'h100, 1'b0, 13'h020);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b000, 32'd5, 32'd5);
    #1 check_output("beq_ok_pre_wrong", 32'(pre_wrong), 32'h0);
    tick();
    #1;
    check_output("beq_ok_br_cnt", 32'(br_cnt), 32'd1);
    check_output("beq_ok_miss_cnt", 32'(miss_cnt), 32'd0);

    // BNE backwards, predicted not-taken, taken; IF branch behind it is dropped
    tick();
    set_if(1'b1, 1'b0, 32'h200, 1'b0, 13'h1FF0);
    tick();
    set_if(1'b1, 1'b1, 32'h400, 1'b0, 13'h010);
    set_id(3'b001, 32'd1, 32'd2);
    #1;
    check_output("bne_pre_wrong", 32'(pre_wrong), 32'h1);
    check_output("bne_flush_if", 32'(flush_if), 32'h1);
    check_output("bne_redirect", redirect_pc, 32'h1F0);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b001, 32'd3, 32'd3);
    #1 check_output("dropped_if_pre_wrong", 32'(pre_wrong), 32'h0);
    tick();
    #1;
    check_output("dropped_br_cnt", 32'(br_cnt), 32'd2);
    check_output("dropped_miss_cnt", 32'(miss_cnt), 32'd1);

    // C.BEQZ predicted taken, not taken -> PC+2
    set_if(1'b1, 1'b1, 32'h300, 1'b1, 13'h010);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b000, 32'd7, 32'd0);
    #1;
    check_output("cbeqz_pre_wrong", 32'(pre_wrong), 32'h1);
    check_output("cbeqz_redirect", redirect_pc, 32'h302);

    // BLT signed: -1 < 1 taken, predicted not-taken
    tick();
    set_if(1'b1, 1'b0, 32'h500, 1'b0, 13'h040);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b100, 32'hFFFF_FFFF, 32'd1);
    #1;
    check_output("blt_pre_wrong", 32'(pre_wrong), 32'h1);
    check_output("blt_redirect", redirect_pc, 32'h540);
    tick();
    #1 check_output("blt_miss_cnt", 32'(miss_cnt), 32'd3);

    // BLTU: 0xFFFFFFFF < 1 false, predicted not-taken; next branch follows back-to-back
    set_if(1'b1, 1'b0, 32'h600, 1'b0, 13'h040);
    tick();
    set_if(1'b1, 1'b1, 32'h700, 1'b0, 13'h008);
    set_id(3'b110, 32'hFFFF_FFFF, 32'd1);
    #1 check_output("bltu_pre_wrong", 32'(pre_wrong), 32'h0);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b111, 32'd1, 32'd2);
    #1;
    check_output("b2b_bgeu_pre_wrong", 32'(pre_wrong), 32'h1);
    check_output("b2b_bgeu_redirect", redirect_pc, 32'h704);
    tick();
    #1;
    check_output("b2b_br_cnt", 32'(br_cnt), 32'd6);
    check_output("b2b_miss_cnt", 32'(miss_cnt), 32'd4);

    // Reserved funct3 resolves not-taken even with equal operands
    set_if(1'b1, 1'b1, 32'h800, 1'b0, 13'h020);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b010, 32'd5, 32'd5);
    #1;
    check_output("f3_010_pre_wrong", 32'(pre_wrong), 32'h1);
    check_output("f3_010_redirect", redirect_pc, 32'h804);
    tick();

    // Mispredict held under a 3-cycle stall, counted once
    set_if(1'b1, 1'b0, 32'h900, 1'b0, 13'h100);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b001, 32'd1, 32'd2);
    stall = 1'b1;
    #1 check_output("stall_pre_wrong_0", 32'(pre_wrong), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check_output($sformatf("stall_pre_wrong_%0d", i + 1), 32'(pre_wrong), 32'h1);
      check_output($sformatf("stall_miss_cnt_%0d", i + 1), 32'(miss_cnt), 32'd5);
    end
    check_output("stall_redirect", redirect_pc, 32'hA00);
    stall = 1'b0;
    tick();
    #1;
    check_output("post_stall_miss_cnt", 32'(miss_cnt), 32'd6);
    check_output("post_stall_br_cnt", 32'(br_cnt), 32'd8);
    check_output("post_stall_pre_wrong", 32'(pre_wrong), 32'h0);

    // Asynchronous reset in the middle of a stalled mispredict
    set_if(1'b1, 1'b0, 32'hA00, 1'b0, 13'h020);
    tick();
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
    set_id(3'b001, 32'd1, 32'd2);
    stall = 1'b1;
    tick();
    #1 check_output("pre_reset_pre_wrong", 32'(pre_wrong), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_output("midreset_pre_wrong", 32'(pre_wrong), 32'h0);
    check_output("midreset_flush_if", 32'(flush_if), 32'h0);
    check_output("midreset_redirect", redirect_pc, 32'h0);
    check_output("midreset_br_cnt", 32'(br_cnt), 32'h0);
    check_output("midreset_miss_cnt", 32'(miss_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;

    // Eight mispredicts: 3-bit counters saturate at 7, 16-bit ones reach 8
    for (int i = 0; i < 8; i++) begin
      set_if(1'b1, 1'b0, 32'h1000 + 32'(i * 16), 1'b0, 13'h040);
      tick();
      set_if(1'b0, 1'b0, 32'h0, 1'b0, 13'h0);
      set_id(3'b001, 32'd1, 32'd2);
      tick();
    end
    #1;
    check_output("sat_br_cnt", 32'(br_cnt_s), 32'd7);
    check_output("sat_miss_cnt", 32'(miss_cnt_s), 32'd7);
    check_output("wide_br_cnt", 32'(br_cnt), 32'd8);
    check_output("wide_miss_cnt", 32'(miss_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
